// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RISC-V funct3 encodings, FSM state codes
// and the word-index width helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned MEM_IDX_W = idx_width(256);

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends the load lane from a read word and
// merges a sub-word store lane into it.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      byte_off,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rd_word,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] ld_value,
  output logic [XLEN-1:0] st_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rd_word[{byte_off, 3'b000} +: 8];
    lane_h = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    case (funct3)
      F3_B:    ld_value = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_BU:   ld_value = {{(XLEN-8){1'b0}}, lane_b};
      F3_H:    ld_value = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_HU:   ld_value = {{(XLEN-16){1'b0}}, lane_h};
      default: ld_value = rd_word;
    endcase

    st_word = rd_word;
    case (funct3)
      F3_B: st_word[{byte_off, 3'b000} +: 8] = st_data[7:0];
      F3_H: begin
        if (byte_off[1]) st_word[31:16] = st_data[15:0];
        else             st_word[15:0]  = st_data[15:0];
      end
      default: st_word = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for a word-wide data_memory without byte enables; sub-word
// stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            o_ready,
  input  logic            i_req_store,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wr_data,
  output logic            o_done,
  output logic            o_fault,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wr_data,
  input  logic [XLEN-1:0] i_mem_rd_data
);

  logic [2:0]      state;
  logic            store_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            fault_q;
  logic            req_fault;
  logic            f3_legal;
  logic            misaligned;
  logic            out_of_range;
  logic [XLEN-1:0] ld_value;
  logic [XLEN-1:0] st_word;

  always_comb begin
    if (i_req_store)
      f3_legal = (i_req_funct3 == F3_B) || (i_req_funct3 == F3_H) || (i_req_funct3 == F3_W);
    else
      f3_legal = (i_req_funct3 == F3_B) || (i_req_funct3 == F3_H) || (i_req_funct3 == F3_W) ||
                 (i_req_funct3 == F3_BU) || (i_req_funct3 == F3_HU);
    misaligned   = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, i_req_addr[XLEN-1:2]} >= XLEN'(MEM_DEPTH);
    req_fault    = !f3_legal || misaligned || out_of_range;
  end

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .byte_off (addr_q[1:0]),
    .funct3   (f3_q),
    .rd_word  (i_mem_rd_data),
    .st_data  (wdata_q),
    .ld_value (ld_value),
    .st_word  (st_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      fault_q     <= 1'b0;
      o_load_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            store_q <= i_req_store;
            f3_q    <= i_req_funct3;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wr_data;
            fault_q <= req_fault;
            state   <= req_fault ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: state <= (store_q && f3_q == F3_W) ? S_DONE : S_WAIT;
        S_WAIT: begin
          // wdata_q switches from raw store data to the merged word for WRITE
          if (store_q) begin
            wdata_q <= st_word;
            state   <= S_WRITE;
          end else begin
            o_load_data <= ld_value;
            state       <= S_DONE;
          end
        end
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready       = (state == S_IDLE) && !rst;
    o_done        = (state == S_DONE) && !rst;
    o_fault       = o_done && fault_q;
    o_mem_rd      = (state == S_ISSUE) && !(store_q && f3_q == F3_W) && !rst;
    o_mem_wr      = ((state == S_WRITE) || ((state == S_ISSUE) && store_q && f3_q == F3_W)) && !rst;
    o_mem_addr    = {2'b00, addr_q[XLEN-1:2]};
    o_mem_wr_data = wdata_q;
  end

endmodule
